stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 134 +++++++++++++
 tb/tb_stage_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle Y86 stage sequencer: walks each instruction through FETCH..PCUPD and halts on faults.
// Optional retired-instruction counter is enabled by defining SEQ_INSTR_COUNT_EN.
`timescale 1ns/1ps

module stage_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        imem_error,
  input  logic        dmem_ack,
  input  logic        dmem_error,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic        mem_req,
  output logic        retire,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALTED
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int             WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  logic [2:0]        r_stat;
  logic [3:0]        r_icode_q;
  logic [WAIT_W-1:0] r_wait;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_stat    <= STAT_AOK;
      r_icode_q <= '0;
      r_wait    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_error) begin
            r_stat  <= STAT_ADR;
            r_state <= S_HALTED;
          end else begin
            r_icode_q <= icode;
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (r_icode_q == 4'h0) begin
            r_stat  <= STAT_HLT;
            r_state <= S_HALTED;
          end else if (r_icode_q > 4'hB) begin
            r_stat  <= STAT_INS;
            r_state <= S_HALTED;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: begin
              r_wait  <= '0;
              r_state <= S_MEM;
            end
            4'h2, 4'h3, 4'h6: r_state <= S_WB;
            default:          r_state <= S_PCUPD;
          endcase
        end
        S_MEM: begin
          // An ack on the final allowed cycle wins over the timeout.
          if (dmem_ack) begin
            if (dmem_error) begin
              r_stat  <= STAT_ADR;
              r_state <= S_HALTED;
            end else if (r_icode_q == 4'h4) begin
              r_state <= S_PCUPD;
            end else begin
              r_state <= S_WB;
            end
          end else if (r_wait == WAIT_LAST) begin
            r_stat  <= STAT_ADR;
            r_state <= S_HALTED;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WB:     r_state <= S_PCUPD;
        S_PCUPD:  r_state <= S_FETCH;
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs: pure decode of the state register, so reset clears them without a clock.
  assign fetch_en  = (r_state == S_FETCH);
  assign decode_en = (r_state == S_DECODE);
  assign exec_en   = (r_state == S_EXEC);
  assign mem_req   = (r_state == S_MEM);
  assign wb_en     = (r_state == S_WB);
  assign pc_en     = (r_state == S_PCUPD);
  assign retire    = (r_state == S_PCUPD);
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign stat      = r_stat;

`ifdef SEQ_INSTR_COUNT_EN
  logic [31:0] r_instr_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                r_instr_count <= '0;
    else if (r_state == S_PCUPD) r_instr_count <= r_instr_count + 32'd1;
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: instruction-level latency model expands into a per-cycle expected trace.
// Expected instr_count follows SEQ_INSTR_COUNT_EN as compiled.
`timescale 1ns/1ps

module tb_stage_sequencer;

  localparam int MEM_TIMEOUT = 16;

  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

  // Expected enable vector order: {fetch, decode, exec, mem_req, wb, pc, retire, busy}
  localparam logic [7:0] E_NONE  = 8'b0000_0000;
  localparam logic [7:0] E_FETCH = 8'b1000_0001;
  localparam logic [7:0] E_DEC   = 8'b0100_0001;
  localparam logic [7:0] E_EXEC  = 8'b0010_0001;
  localparam logic [7:0] E_MEM   = 8'b0001_0001;
  localparam logic [7:0] E_WB    = 8'b0000_1001;
  localparam logic [7:0] E_PC    = 8'b0000_0111;

`ifdef SEQ_INSTR_COUNT_EN
  localparam bit COUNT_ON = 1'b1;
`else
  localparam bit COUNT_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start, imem_error, dmem_ack, dmem_error;
  logic [3:0]  icode;
  logic        fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req, retire, busy;
  logic [2:0]  stat;
  logic [31:0] instr_count;
  logic [7:0]  dut_en;

  stage_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .icode(icode),
    .imem_error(imem_error), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .wb_en(wb_en), .pc_en(pc_en), .mem_req(mem_req), .retire(retire),
    .stat(stat), .busy(busy), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  assign dut_en = {fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en, retire, busy};

  typedef struct {
    logic [7:0]  en;
    logic [2:0]  stat;
    logic [31:0] cnt;
    logic        start;
    logic [3:0]  icode;
    logic        ierr;
    logic        ack;
    logic        derr;
  } phase_t;

  phase_t plan_q[$];
  phase_t exp_ph;
  bit     chk_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Architectural model state
  logic [2:0]  m_stat;
  logic [31:0] m_count;

  // Observations of the DUT used for literal latency checks
  int cyc = 0;
  int first_fetch;
  int obs_mem;
  int retire_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
    return COUNT_ON ? m_count : 32'd0;
  endfunction

  function automatic void push(input logic [7:0] en, input logic st, input logic [3:0] ic,
                               input logic ie, input logic ak, input logic de);
    phase_t p;
    p.en = en; p.stat = m_stat; p.cnt = exp_cnt();
    p.start = st; p.icode = ic; p.ierr = ie; p.ack = ak; p.derr = de;
    plan_q.push_back(p);
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic void plan_idle(input logic st);
    push(E_NONE, st, rnd4(), 1'b0, 1'b0, 1'b0);
  endfunction

  // Halted must ignore start, acks and errors entirely.
  function automatic void plan_halted(input int n);
    for (int i = 0; i < n; i++) push(E_NONE, 1'b1, rnd4(), 1'b1, 1'b1, 1'b1);
  endfunction

  // One instruction from the latency rules; n_ack = MEM cycle carrying the ack (0 = never).
  function automatic void plan_instr(input logic [3:0] ic, input int n_ack,
                                     input logic ierr, input logic derr);
    bit is_mem;
    push(E_FETCH, 1'b0, ic, ierr, 1'b0, 1'b0);
    if (ierr) begin m_stat = ADR; return; end
    push(E_DEC, 1'b0, rnd4(), 1'b0, 1'b0, 1'b0);
    if (ic == 4'h0) begin m_stat = HLT; return; end
    if (ic > 4'hB)  begin m_stat = INS; return; end
    push(E_EXEC, 1'b0, rnd4(), 1'b0, 1'b0, 1'b0);
    is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    if (is_mem) begin
      for (int k = 1; k <= MEM_TIMEOUT; k++) begin
        push(E_MEM, 1'b0, rnd4(), 1'b0, k == n_ack, derr && (k == n_ack));
        if (k == n_ack) break;
      end
      if (n_ack < 1 || n_ack > MEM_TIMEOUT || derr) begin m_stat = ADR; return; end
    end
    if (!(ic inside {4'h1, 4'h7, 4'h4})) push(E_WB, 1'b0, rnd4(), 1'b0, 1'b0, 1'b0);
    push(E_PC, 1'b0, rnd4(), 1'b0, 1'b0, 1'b0);
    m_count++;
  endfunction

  task automatic run_plan();
    while (plan_q.size() > 0) begin
      @(posedge CLK); #1;
      exp_ph     = plan_q.pop_front();
      start      = exp_ph.start;
      icode      = exp_ph.icode;
      imem_error = exp_ph.ierr;
      dmem_ack   = exp_ph.ack;
      dmem_error = exp_ph.derr;
      chk_en     = 1'b1;
    end
    @(negedge CLK); #1;
  endtask

  task automatic clear_obs();
    first_fetch = -1;
    obs_mem     = 0;
    retire_q.delete();
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    RST_N = 1'b0;
    start = 1'b0; icode = 4'h0; imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_enables", 32'(dut_en), 32'(E_NONE));
    check("reset_stat", 32'(stat), 32'(AOK));
    check("reset_count", instr_count, 32'd0);
    @(negedge CLK);
    RST_N   = 1'b1;
    m_stat  = AOK;
    m_count = 32'd0;
    clear_obs();
  endtask

  function automatic int retire_at(input int i);
    return (retire_q.size() > i && first_fetch >= 0) ? retire_q[i] - first_fetch : -1;
  endfunction

  // Single compare process: every cycle with a planned phase is checked.
  always @(negedge CLK) begin
    cyc++;
    if (chk_en) begin
      check("enables", 32'(dut_en), 32'(exp_ph.en));
      check("stat", 32'(stat), 32'(exp_ph.stat));
      check("instr_count", instr_count, exp_ph.cnt);
      if (fetch_en && first_fetch < 0) first_fetch = cyc;
      if (mem_req) obs_mem++;
      if (retire)  retire_q.push_back(cyc);
    end
  end

  initial begin
    // Run A: nop stream, then halt.
    do_reset();
    plan_idle(1'b0); plan_idle(1'b0); plan_idle(1'b1);
    repeat (3) plan_instr(4'h1, 0, 1'b0, 1'b0);
    plan_instr(4'h0, 0, 1'b0, 1'b0);
    plan_halted(3);
    run_plan();
    check("nop_retire1_cycle", 32'(retire_at(0)), 32'd3);
    check("nop_retire2_cycle", 32'(retire_at(1)), 32'd7);
    check("nop_retire3_cycle", 32'(retire_at(2)), 32'd11);
    check("nop_final_count", instr_count, COUNT_ON ? 32'd3 : 32'd0);
    check("hlt_stat", 32'(stat), 32'(HLT));

    // Run B: memory and write-back classes, ending with a data fault.
    do_reset();
    plan_idle(1'b1);
    plan_instr(4'h5, 3, 1'b0, 1'b0);
    plan_instr(4'h2, 0, 1'b0, 1'b0);
    plan_instr(4'h7, 0, 1'b0, 1'b0);
    plan_instr(4'h4, 1, 1'b0, 1'b0);
    plan_instr(4'h3, 0, 1'b0, 1'b0);
    plan_instr(4'h6, 0, 1'b0, 1'b0);
    plan_instr(4'hA, 2, 1'b0, 1'b0);
    plan_instr(4'hB, 1, 1'b0, 1'b0);
    plan_instr(4'h8, 2, 1'b0, 1'b1);
    plan_halted(3);
    run_plan();
    check("mrmovl_retire_cycle", 32'(retire_at(0)), 32'd7);
    check("mix_mem_cycles", 32'(obs_mem), 32'd9);
    check("mix_retires", 32'(retire_q.size()), 32'd8);
    check("dmem_err_stat", 32'(stat), 32'(ADR));

    // Run C: rmmovl with no ack times out.
    do_reset();
    plan_idle(1'b1);
    plan_instr(4'h4, 0, 1'b0, 1'b0);
    plan_halted(3);
    run_plan();
    check("timeout_mem_cycles", 32'(obs_mem), 32'd16);
    check("timeout_retires", 32'(retire_q.size()), 32'd0);
    check("timeout_stat", 32'(stat), 32'(ADR));
    check("timeout_busy", 32'(busy), 32'd0);

    // Run D: illegal opcode, start ignored while halted.
    do_reset();
    plan_idle(1'b1);
    plan_instr(4'hC, 0, 1'b0, 1'b0);
    plan_halted(4);
    run_plan();
    check("ins_stat", 32'(stat), 32'(INS));

    // Run E: reset pulse in the middle of MEM, then restart.
    do_reset();
    plan_idle(1'b1);
    push(E_FETCH, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    push(E_DEC,   1'b0, rnd4(), 1'b0, 1'b0, 1'b0);
    push(E_EXEC,  1'b0, rnd4(), 1'b0, 1'b0, 1'b0);
    repeat (3) push(E_MEM, 1'b0, rnd4(), 1'b0, 1'b0, 1'b0);
    run_plan();
    chk_en = 1'b0;
    RST_N  = 1'b0;
    #1;
    check("async_rst_enables", 32'(dut_en), 32'(E_NONE));
    check("async_rst_stat", 32'(stat), 32'(AOK));
    @(negedge CLK);
    RST_N   = 1'b1;
    m_stat  = AOK;
    m_count = 32'd0;
    clear_obs();
    plan_idle(1'b0); plan_idle(1'b1);
    plan_instr(4'h1, 0, 1'b0, 1'b0);
    plan_instr(4'h1, 0, 1'b0, 1'b0);
    plan_instr(4'h0, 0, 1'b0, 1'b0);
    plan_halted(2);
    run_plan();
    check("restart_first_retire", 32'(retire_at(0)), 32'd3);
    check("restart_hlt_stat", 32'(stat), 32'(HLT));
    check("restart_count", instr_count, COUNT_ON ? 32'd2 : 32'd0);

    // Run F: ack exactly on the timeout cycle wins, then a fetch fault.
    do_reset();
    plan_idle(1'b1);
    plan_instr(4'h9, MEM_TIMEOUT, 1'b0, 1'b0);
    plan_instr(4'h2, 0, 1'b1, 1'b0);
    plan_halted(3);
    run_plan();
    check("limit_ack_mem_cycles", 32'(obs_mem), 32'd16);
    check("limit_ack_retires", 32'(retire_q.size()), 32'd1);
    check("limit_ack_retire_cycle", 32'(retire_at(0)), 32'd20);
    check("imem_err_stat", 32'(stat), 32'(ADR));

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
